misr_sig_ctl: RTL and testbench
===============================

# misr_sig_ctl

Parametrised multiple-input signature register with session control, the next generation of our fixed 15-bit, 3-input MISR. It compacts an NIN-bit response word per enabled cycle into a WIDTH-bit signature using a configurable feedback polynomial. It counts a programmed number of patterns and compares the final signature against a golden value. It sits at the output of a circuit under test in the BIST path and reports busy/done/pass to the test controller.

## Interface
- WIDTH, 15: signature width; 2..64.
- NIN, 3: response inputs per cycle; 1..WIDTH.
- POLY, 15'h0003: feedback taps, bit i set means s[WIDTH-1] is XORed into bit i. POLY[0] is ignored (implicit 1). Default is x^15+x+1.
- SEED, 0: signature value loaded at reset and at start.
- PATTERNS, 16: compacted words per session; ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  begin session (accepted in IDLE or DONE).
- abort  in  1  end session immediately, go to IDLE.
- en  in  1  compact d this cycle (RUN only).
- d  in  NIN  response word.
- golden  in  WIDTH  expected signature; sampled on the final compaction cycle.
- sig  out  WIDTH  current signature register.
- count  out  $clog2(PATTERNS+1)  patterns compacted this session.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 when final sig == golden.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: sig and count hold. start=1 loads sig=SEED, count=0, pass=0, next state RUN.
- RUN:
  - en=0: hold all state.
  - en=1: compact d and increment count.
  - When en=1 and count==PATTERNS-1: final compaction, pass<=(next_sig==golden), next state DONE.
  - start in RUN is ignored.
- DONE: sig, count and pass hold. start behaves as in IDLE (back-to-back sessions).
- abort=1 in any state: next state IDLE, no compaction that cycle, sig/count hold, pass<=0. abort has priority over start and en.
- Compaction (fb = sig[WIDTH-1]):
  - next[0] = fb ^ d[0].
  - next[i] = sig[i-1] ^ (POLY[i] & fb) ^ (i<NIN ? d[i] : 0) for i = 1..WIDTH-1.
  - d is zero-extended; no bits are truncated since NIN ≤ WIDTH.
- count never exceeds PATTERNS; it holds PATTERNS in DONE.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system): state=IDLE, sig=SEED, count=0, busy=0, done=0, pass=0.
- All outputs are registered.
- busy rises 1 cycle after the start edge.
- Each en=1 cycle in RUN updates sig at that clock edge.
- done and pass rise at the edge of the final compaction, in the same cycle busy falls.
- Minimum session is PATTERNS+1 cycles from start to done.
- Reset asserted mid-session returns to reset values immediately; the session is not resumed.

## Test plan
- Reset: RST_N low mid-RUN (any config) -> sig=SEED, count=0, busy=done=pass=0 asynchronously; state IDLE after release.
- Shift/feedback, defaults, SEED=1, PATTERNS=15, d=0 throughout: after 14 compactions sig=15'h4000; after the 15th, sig=15'h0003 and done=1. golden=15'h0003 -> pass=1.
- Input injection, WIDTH=4, NIN=2, POLY=4'b0011, SEED=0, PATTERNS=5, d sequence 01,00,00,00,00:
  - sig steps 0001, 0010, 0100, 1000, 0011.
  - golden=4'h3 -> pass=1; golden=4'h2 -> pass=0.
- en gaps: same as the previous scenario with en=0 for 3 cycles after the second word -> sig/count hold during gaps, same final sig 0011, done 3 cycles later.
- abort and start priority:
  - abort at count=2 -> IDLE, sig holds, pass=0.
  - start during RUN has no effect.
  - start in DONE reloads SEED, count=0, busy 1 cycle later.
- Back-to-back: start asserted in the first DONE cycle -> new session; second session's signature is independent of the first (reseeded).

Source files
------------

// File: rtl/misr_sig_ctl.sv
// Multiple-input signature register with session control: compacts NIN-bit
// response words into a WIDTH-bit signature and compares it with a golden value.
module misr_sig_ctl #(
    parameter int unsigned       WIDTH    = 15,
    parameter int unsigned       NIN      = 3,
    parameter logic [WIDTH-1:0]  POLY     = WIDTH'(15'h0003),
    parameter logic [WIDTH-1:0]  SEED     = '0,
    parameter int unsigned       PATTERNS = 16
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          en,
    input  logic [NIN-1:0]                d,
    input  logic [WIDTH-1:0]              golden,
    output logic [WIDTH-1:0]              sig,
    output logic [$clog2(PATTERNS+1)-1:0] count,
    output logic                          busy,
    output logic                          done,
    output logic                          pass
);

    localparam int unsigned      CW   = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0]    LAST = CW'(PATTERNS - 1);
    // Bit 0 always takes the feedback, whatever POLY[0] says.
    localparam logic [WIDTH-1:0] TAPS = POLY | WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sig_d;
    logic [CW-1:0]    count_d;
    logic             pass_d;
    logic             busy_d;
    logic             done_d;
    logic [WIDTH-1:0] comp_c;

    // One compaction step: shift, fold the MSB back through the taps, inject d.
    assign comp_c = {sig[WIDTH-2:0], 1'b0}
                  ^ (TAPS & {WIDTH{sig[WIDTH-1]}})
                  ^ WIDTH'(d);

    always_comb begin
        state_d = state_q;
        sig_d   = sig;
        count_d = count;
        pass_d  = pass;

        if (abort) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_RUN;
                        sig_d   = SEED;
                        count_d = '0;
                        pass_d  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        sig_d   = comp_c;
                        count_d = count + CW'(1);
                        if (count == LAST) begin
                            state_d = S_DONE;
                            pass_d  = (comp_c == golden);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sig     <= SEED;
            count   <= '0;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sig     <= sig_d;
            count   <= count_d;
            pass    <= pass_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_misr_sig_ctl.sv
// Bench for misr_sig_ctl: two configurations checked every cycle against a
// polynomial-arithmetic session model, plus hand-computed directed expectations.
module tb_misr_sig_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Config A: defaults with SEED=1, PATTERNS=15
    logic        a_start, a_abort, a_en;
    logic [2:0]  a_d;
    logic [14:0] a_golden, a_sig;
    logic [3:0]  a_count;
    logic        a_busy, a_done, a_pass;

    // Config B: WIDTH=4, NIN=2, POLY=0011, SEED=0, PATTERNS=5
    logic        b_start, b_abort, b_en;
    logic [1:0]  b_d;
    logic [3:0]  b_golden, b_sig;
    logic [2:0]  b_count;
    logic        b_busy, b_done, b_pass;

    misr_sig_ctl #(.WIDTH(15), .NIN(3), .POLY(15'h0003), .SEED(15'h0001), .PATTERNS(15)) u_a (
        .CLK(clk), .RST_N(rst_n), .start(a_start), .abort(a_abort), .en(a_en),
        .d(a_d), .golden(a_golden), .sig(a_sig), .count(a_count),
        .busy(a_busy), .done(a_done), .pass(a_pass));

    misr_sig_ctl #(.WIDTH(4), .NIN(2), .POLY(4'b0011), .SEED(4'h0), .PATTERNS(5)) u_b (
        .CLK(clk), .RST_N(rst_n), .start(b_start), .abort(b_abort), .en(b_en),
        .d(b_d), .golden(b_golden), .sig(b_sig), .count(b_count),
        .busy(b_busy), .done(b_done), .pass(b_pass));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session model: signature is a polynomial, compaction is s*x mod P(x) + d.
    typedef struct {
        logic [63:0] sig;
        int          count;
        bit          run;
        bit          done;
        bit          pass;
    } mdl_t;

    function automatic logic [63:0] mul_x(input logic [63:0] s, input int w, input logic [63:0] poly);
        logic [64:0] t;
        logic [64:0] p;
        t = {1'b0, s} << 1;
        p = (65'd1 << w) | {1'b0, poly} | 65'd1;
        if (t[w]) t = t ^ p;
        return t[63:0] & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic mdl_t mdl_reset(input logic [63:0] seed);
        mdl_t r;
        r.sig = seed; r.count = 0; r.run = 0; r.done = 0; r.pass = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int w, input int pats,
                                      input logic [63:0] poly, input logic [63:0] seed,
                                      input bit s, input bit a, input bit e,
                                      input logic [63:0] dv, input logic [63:0] g);
        mdl_t r;
        r = m;
        if (a) begin
            r.run = 0; r.done = 0; r.pass = 0;
        end else if (!m.run && s) begin
            r.sig = seed; r.count = 0; r.pass = 0; r.run = 1; r.done = 0;
        end else if (m.run && e) begin
            r.sig = mul_x(m.sig, w, poly) ^ dv;
            r.count = m.count + 1;
            if (r.count == pats) begin
                r.run = 0; r.done = 1; r.pass = (r.sig == g);
            end
        end
        return r;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mdl_reset(64'h1);
            mb <= mdl_reset(64'h0);
        end else begin
            ma <= mdl_step(ma, 15, 15, 64'h3, 64'h1, a_start, a_abort, a_en, 64'(a_d), 64'(a_golden));
            mb <= mdl_step(mb, 4, 5, 64'h3, 64'h0, b_start, b_abort, b_en, 64'(b_d), 64'(b_golden));
        end
    end

    always @(negedge clk) begin
        chk("a_sig",   64'(a_sig),   ma.sig);
        chk("a_count", 64'(a_count), 64'(ma.count));
        chk("a_busy",  64'(a_busy),  64'(ma.run));
        chk("a_done",  64'(a_done),  64'(ma.done));
        chk("a_pass",  64'(a_pass),  64'(ma.pass));
        chk("b_sig",   64'(b_sig),   mb.sig);
        chk("b_count", 64'(b_count), 64'(mb.count));
        chk("b_busy",  64'(b_busy),  64'(mb.run));
        chk("b_done",  64'(b_done),  64'(mb.done));
        chk("b_pass",  64'(b_pass),  64'(mb.pass));
    end

    task automatic cyc_a(input bit s, input bit a, input bit e, input logic [2:0] dv, input logic [14:0] g);
        a_start = s; a_abort = a; a_en = e; a_d = dv; a_golden = g;
        @(posedge clk); #1;
        a_start = 0; a_abort = 0; a_en = 0;
    endtask

    task automatic cyc_b(input bit s, input bit a, input bit e, input logic [1:0] dv, input logic [3:0] g);
        b_start = s; b_abort = a; b_en = e; b_d = dv; b_golden = g;
        @(posedge clk); #1;
        b_start = 0; b_abort = 0; b_en = 0;
    endtask

    logic [3:0] exp_b [5];

    initial begin
        exp_b = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
        a_start = 0; a_abort = 0; a_en = 0; a_d = '0; a_golden = '0;
        b_start = 0; b_abort = 0; b_en = 0; b_d = '0; b_golden = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst a_sig", 64'(a_sig), 64'h1);
        chk("rst a_busy", 64'(a_busy), 64'h0);
        chk("rst b_count", 64'(b_count), 64'h0);

        // A: pure shift/feedback with d=0
        cyc_a(1, 0, 0, 3'd0, 15'h0003);
        chk("a start busy", 64'(a_busy), 64'h1);
        repeat (14) cyc_a(0, 0, 1, 3'd0, 15'h0003);
        chk("a sig after 14", 64'(a_sig), 64'h4000);
        chk("a busy after 14", 64'(a_busy), 64'h1);
        cyc_a(0, 0, 1, 3'd0, 15'h0003);
        chk("a final sig", 64'(a_sig), 64'h0003);
        chk("a done", 64'(a_done), 64'h1);
        chk("a busy fell", 64'(a_busy), 64'h0);
        chk("a pass", 64'(a_pass), 64'h1);
        chk("a count", 64'(a_count), 64'd15);
        cyc_a(0, 0, 1, 3'd7, 15'h0);
        chk("a done hold sig", 64'(a_sig), 64'h0003);
        chk("a done hold count", 64'(a_count), 64'd15);

        // B: input injection, golden match
        cyc_b(1, 0, 0, 2'd0, 4'h3);
        for (int i = 0; i < 5; i++) begin
            cyc_b(0, 0, 1, (i == 0) ? 2'b01 : 2'b00, 4'h3);
            chk("b step sig", 64'(b_sig), 64'(exp_b[i]));
        end
        chk("b1 done", 64'(b_done), 64'h1);
        chk("b1 pass", 64'(b_pass), 64'h1);

        // B: back-to-back start in first DONE cycle, golden mismatch
        cyc_b(1, 0, 0, 2'd0, 4'h2);
        chk("b2 busy", 64'(b_busy), 64'h1);
        chk("b2 reseed", 64'(b_sig), 64'h0);
        chk("b2 count", 64'(b_count), 64'h0);
        chk("b2 done low", 64'(b_done), 64'h0);
        for (int i = 0; i < 5; i++) cyc_b(0, 0, 1, (i == 0) ? 2'b01 : 2'b00, 4'h2);
        chk("b2 sig", 64'(b_sig), 64'h3);
        chk("b2 done", 64'(b_done), 64'h1);
        chk("b2 pass", 64'(b_pass), 64'h0);

        // B: en gaps, start during RUN ignored
        cyc_b(1, 0, 0, 2'd0, 4'h3);
        cyc_b(0, 0, 1, 2'b01, 4'h3);
        cyc_b(0, 0, 1, 2'b00, 4'h3);
        for (int i = 0; i < 3; i++) begin
            cyc_b((i == 1), 0, 0, 2'b11, 4'h3);
            chk("b gap sig", 64'(b_sig), 64'h2);
            chk("b gap count", 64'(b_count), 64'h2);
        end
        repeat (3) cyc_b(0, 0, 1, 2'b00, 4'h3);
        chk("b3 sig", 64'(b_sig), 64'h3);
        chk("b3 done", 64'(b_done), 64'h1);
        chk("b3 pass", 64'(b_pass), 64'h1);

        // B: abort at count=2 beats start and en
        cyc_b(1, 0, 0, 2'd0, 4'h0);
        cyc_b(0, 0, 1, 2'b01, 4'h0);
        cyc_b(0, 0, 1, 2'b00, 4'h0);
        cyc_b(1, 1, 1, 2'b11, 4'h0);
        chk("abort busy", 64'(b_busy), 64'h0);
        chk("abort done", 64'(b_done), 64'h0);
        chk("abort pass", 64'(b_pass), 64'h0);
        chk("abort sig", 64'(b_sig), 64'h2);
        chk("abort count", 64'(b_count), 64'h2);
        cyc_b(0, 0, 1, 2'b01, 4'h0);
        chk("idle en ignored", 64'(b_sig), 64'h2);

        // A: asynchronous reset mid-session
        cyc_a(1, 0, 0, 3'd0, 15'h0);
        repeat (3) cyc_a(0, 0, 1, 3'b101, 15'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst a_sig", 64'(a_sig), 64'h1);
        chk("arst a_count", 64'(a_count), 64'h0);
        chk("arst a_busy", 64'(a_busy), 64'h0);
        chk("arst a_done", 64'(a_done), 64'h0);
        chk("arst b_sig", 64'(b_sig), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc_a(0, 0, 1, 3'b001, 15'h0);
        chk("post rst idle", 64'(a_busy), 64'h0);
        chk("post rst sig", 64'(a_sig), 64'h1);
        cyc_a(1, 0, 0, 3'd0, 15'h0);
        chk("post rst start", 64'(a_busy), 64'h1);
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
